// File: rtl/sfp_frame_handler_pkg.sv
// Shared MPS definitions: handler state encoding and default frame geometry/timeout.
// Imported by the SFP frame handler and reused by the core and DSP handler.
package sfp_frame_handler_pkg;

  localparam int SFP_TDATA_WIDTH     = 64;
  localparam int SFP_NUMBER_OF_FRAME = 2;
  localparam int SFP_TIMEOUT_CYCLES  = 10000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TX   = 2'd1,
    ST_RX   = 2'd2,
    ST_DONE = 2'd3
  } sfp_state_e;

endpackage

// File: rtl/sfp_rx_deframer.sv
// Collects RX beats into a shadow frame and checks that tlast falls on the final beat.
// o_frame already includes the beat being accepted this cycle, so the parent can capture it directly.
module sfp_rx_deframer
  import sfp_frame_handler_pkg::*;
#(
  parameter int W     = SFP_TDATA_WIDTH,
  parameter int N     = SFP_NUMBER_OF_FRAME,
  parameter int IDX_W = (SFP_NUMBER_OF_FRAME > 1) ? $clog2(SFP_NUMBER_OF_FRAME) : 1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_clear,
  input  logic           i_active,
  input  logic [W-1:0]   s_axis_tdata,
  input  logic           s_axis_tvalid,
  input  logic           s_axis_tlast,
  output logic           o_complete,
  output logic           o_error,
  output logic [N-1:0][W-1:0] o_frame
);

  logic [IDX_W-1:0] idx_reg;
  logic             beat;
  logic             last_slot;

  assign beat       = i_active & s_axis_tvalid;
  assign last_slot  = (idx_reg == IDX_W'(N - 1));
  assign o_complete = beat & s_axis_tlast & last_slot;
  assign o_error    = beat & (s_axis_tlast ^ last_slot);

  // Index returns to 0 on any frame-terminating beat, good or bad.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      idx_reg <= '0;
    end else if (i_clear) begin
      idx_reg <= '0;
    end else if (beat) begin
      idx_reg <= (s_axis_tlast || last_slot) ? '0 : idx_reg + IDX_W'(1);
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_slot
    logic [W-1:0] shadow_reg;
    logic         hit;

    assign hit = beat && (idx_reg == IDX_W'(gi));

    always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
        shadow_reg <= '0;
      end else if (i_clear || o_error) begin
        shadow_reg <= '0;
      end else if (hit) begin
        shadow_reg <= s_axis_tdata;
      end
    end

    assign o_frame[gi] = hit ? s_axis_tdata : shadow_reg;
  end

endmodule

// File: rtl/sfp_frame_handler.sv
// SFP exchange engine: sends one multi-beat frame over Aurora TX, then waits for the
// slave's reply frame on RX, with timeout, tlast checking and link-drop abort.
module sfp_frame_handler
  import sfp_frame_handler_pkg::*;
#(
  parameter int C_AXIS_TDATA_WIDTH = SFP_TDATA_WIDTH,
  parameter int C_NUMBER_OF_FRAME  = SFP_NUMBER_OF_FRAME,
  parameter int C_DATA_FRAME_BIT   = C_AXIS_TDATA_WIDTH * C_NUMBER_OF_FRAME,
  parameter int C_TIMEOUT_CYCLES   = SFP_TIMEOUT_CYCLES
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_tx_start_flag,
  input  logic [C_DATA_FRAME_BIT-1:0]   i_tx_data,
  output logic [C_DATA_FRAME_BIT-1:0]   o_rx_data,
  output logic                          o_rx_end_flag,
  output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  input  logic                          i_channel_up,
  output logic                          o_busy,
  output logic                          o_timeout,
  output logic                          o_frame_err
);

  localparam int W      = C_AXIS_TDATA_WIDTH;
  localparam int N      = C_NUMBER_OF_FRAME;
  localparam int BEAT_W = (N > 1) ? $clog2(N) : 1;
  localparam int TO_W   = $clog2(C_TIMEOUT_CYCLES + 1);

  sfp_state_e state_reg, state_next;

  logic                        start_d_reg;
  logic [N-1:0][W-1:0]         tx_data_reg;
  logic [C_DATA_FRAME_BIT-1:0] rx_data_reg;
  logic [BEAT_W-1:0]           beat_reg;
  logic [TO_W-1:0]             timeout_cnt_reg;
  logic                        timeout_reg;
  logic                        frame_err_reg;

  logic                        start_rise;
  logic                        tx_hs;
  logic                        tx_last_beat;
  logic                        to_expired;
  logic                        load_tx;
  logic                        enter_rx;
  logic                        store_rx;
  logic                        set_timeout;
  logic                        set_frame_err;
  logic                        rx_active;
  logic                        rx_complete;
  logic                        rx_error;
  logic [N-1:0][W-1:0]         rx_frame;

  assign start_rise   = i_tx_start_flag & ~start_d_reg;
  assign tx_hs        = (state_reg == ST_TX) && m_axis_tready;
  assign tx_last_beat = (beat_reg == BEAT_W'(N - 1));
  assign to_expired   = (timeout_cnt_reg == TO_W'(C_TIMEOUT_CYCLES - 1));
  assign rx_active    = (state_reg == ST_RX) && i_channel_up;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Link drop outranks everything; completion outranks both frame error and timeout.
  always_comb begin
    state_next    = state_reg;
    load_tx       = 1'b0;
    enter_rx      = 1'b0;
    store_rx      = 1'b0;
    set_timeout   = 1'b0;
    set_frame_err = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start_rise && i_channel_up) begin
          state_next = ST_TX;
          load_tx    = 1'b1;
        end
      end
      ST_TX: begin
        if (!i_channel_up) begin
          state_next = ST_IDLE;
        end else if (tx_hs && tx_last_beat) begin
          state_next = ST_RX;
          enter_rx   = 1'b1;
        end
      end
      ST_RX: begin
        if (!i_channel_up) begin
          state_next = ST_IDLE;
        end else if (rx_complete) begin
          state_next = ST_DONE;
          store_rx   = 1'b1;
        end else if (rx_error) begin
          state_next    = ST_IDLE;
          set_frame_err = 1'b1;
        end else if (to_expired) begin
          state_next  = ST_IDLE;
          set_timeout = 1'b1;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      start_d_reg     <= 1'b0;
      tx_data_reg     <= '0;
      rx_data_reg     <= '0;
      beat_reg        <= '0;
      timeout_cnt_reg <= '0;
      timeout_reg     <= 1'b0;
      frame_err_reg   <= 1'b0;
    end else begin
      start_d_reg <= i_tx_start_flag;
      if (load_tx) tx_data_reg <= i_tx_data;
      if (load_tx)                         beat_reg <= '0;
      else if (tx_hs && !tx_last_beat)     beat_reg <= beat_reg + BEAT_W'(1);
      if (load_tx || enter_rx)             timeout_cnt_reg <= '0;
      else if (state_reg == ST_RX)         timeout_cnt_reg <= timeout_cnt_reg + TO_W'(1);
      if (load_tx)                         timeout_reg <= 1'b0;
      else if (set_timeout)                timeout_reg <= 1'b1;
      if (load_tx)                         frame_err_reg <= 1'b0;
      else if (set_frame_err)              frame_err_reg <= 1'b1;
      // Captured on the completing beat so data is valid throughout the DONE cycle.
      if (store_rx) rx_data_reg <= rx_frame;
    end
  end

  sfp_rx_deframer #(
    .W     (W),
    .N     (N),
    .IDX_W (BEAT_W)
  ) u_deframer (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_clear       (enter_rx),
    .i_active      (rx_active),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .o_complete    (rx_complete),
    .o_error       (rx_error),
    .o_frame       (rx_frame)
  );

  assign m_axis_tvalid = (state_reg == ST_TX);
  assign m_axis_tlast  = (state_reg == ST_TX) && tx_last_beat;
  assign m_axis_tdata  = (state_reg == ST_TX) ? tx_data_reg[beat_reg] : '0;
  assign o_rx_data     = rx_data_reg;
  assign o_rx_end_flag = (state_reg == ST_DONE);
  assign o_busy        = (state_reg != ST_IDLE);
  assign o_timeout     = timeout_reg;
  assign o_frame_err   = frame_err_reg;

endmodule

// File: tb/tb_sfp_frame_handler.sv
// Directed bench for sfp_frame_handler: a per-cycle compare process checks the DUT against
// expectations derived from the exchange rules, plus literal pins on key results.
module tb_sfp_frame_handler;

  localparam int W   = 64;
  localparam int N   = 2;
  localparam int DFB = W * N;
  localparam int T   = 16;

  logic           i_clk = 1'b0;
  logic           i_rst = 1'b0;
  logic           i_tx_start_flag = 1'b0;
  logic [DFB-1:0] i_tx_data = '0;
  logic [DFB-1:0] o_rx_data;
  logic           o_rx_end_flag;
  logic [W-1:0]   m_axis_tdata;
  logic           m_axis_tvalid;
  logic           m_axis_tlast;
  logic           m_axis_tready = 1'b1;
  logic [W-1:0]   s_axis_tdata = '0;
  logic           s_axis_tvalid = 1'b0;
  logic           s_axis_tlast = 1'b0;
  logic           i_channel_up = 1'b1;
  logic           o_busy;
  logic           o_timeout;
  logic           o_frame_err;

  sfp_frame_handler #(
    .C_AXIS_TDATA_WIDTH (W),
    .C_NUMBER_OF_FRAME  (N),
    .C_DATA_FRAME_BIT   (DFB),
    .C_TIMEOUT_CYCLES   (T)
  ) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_tx_start_flag (i_tx_start_flag),
    .i_tx_data       (i_tx_data),
    .o_rx_data       (o_rx_data),
    .o_rx_end_flag   (o_rx_end_flag),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tready   (m_axis_tready),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tlast    (s_axis_tlast),
    .i_channel_up    (i_channel_up),
    .o_busy          (o_busy),
    .o_timeout       (o_timeout),
    .o_frame_err     (o_frame_err)
  );

  always #5 i_clk = ~i_clk;

  int n_pass  = 0;
  int n_total = 0;

  // Model state, written only by the stimulus process.
  logic           chk_on = 1'b0;
  logic [DFB-1:0] exp_rx_data = '0;
  logic           exp_end = 1'b0;
  logic           exp_timeout = 1'b0;
  logic           exp_frame_err = 1'b0;
  logic           exp_busy = 1'b0;
  logic [W:0]     exp_beat [16];
  int             exp_wr = 0;

  // Monitor bookkeeping, written only by the compare process.
  int             hs_cnt = 0;
  int             last_hs_cnt = 0;
  int             end_cnt = 0;
  logic [W-1:0]   hs_log [16];
  logic           prev_stall = 1'b0;
  logic [W-1:0]   prev_tdata = '0;
  logic           prev_tlast = 1'b0;

  task automatic chk(input string name, input logic [DFB-1:0] act, input logic [DFB-1:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Per-cycle compare against the model, plus TX scoreboard and stall-stability checks.
  initial begin
    forever begin
      @(negedge i_clk);
      if (chk_on) begin
        chk("rx_data", o_rx_data, exp_rx_data);
        chk("rx_end_flag", DFB'(o_rx_end_flag), DFB'(exp_end));
        chk("timeout", DFB'(o_timeout), DFB'(exp_timeout));
        chk("frame_err", DFB'(o_frame_err), DFB'(exp_frame_err));
        chk("busy", DFB'(o_busy), DFB'(exp_busy));
        if (prev_stall && m_axis_tvalid) begin
          chk("tdata_hold", DFB'(m_axis_tdata), DFB'(prev_tdata));
          chk("tlast_hold", DFB'(m_axis_tlast), DFB'(prev_tlast));
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (hs_cnt >= exp_wr) begin
            chk("tx_unexpected_beat", DFB'(m_axis_tvalid), DFB'(0));
          end else begin
            chk("tx_tdata", DFB'(m_axis_tdata), DFB'(exp_beat[hs_cnt % 16][W-1:0]));
            chk("tx_tlast", DFB'(m_axis_tlast), DFB'(exp_beat[hs_cnt % 16][W]));
          end
          $display("tx beat %0d data=%h last=%b", hs_cnt, m_axis_tdata, m_axis_tlast);
          hs_log[hs_cnt % 16] = m_axis_tdata;
          hs_cnt++;
          if (m_axis_tlast) last_hs_cnt++;
        end
        if (o_rx_end_flag) begin
          end_cnt++;
          $display("rx frame done data=%h", o_rx_data);
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_tdata = m_axis_tdata;
        prev_tlast = m_axis_tlast;
      end
    end
  end

  // mode 0: tready high; mode 1: tready toggles each cycle; mode 2: return right after the start edge.
  task automatic start_exchange(input logic [DFB-1:0] data, input int mode);
    int base;
    bit ok;
    i_tx_data = data;
    if (mode != 2) begin
      for (int k = 0; k < N; k++) begin
        exp_beat[exp_wr % 16] = {(k == N - 1), data[k*W +: W]};
        exp_wr++;
      end
    end
    base = last_hs_cnt;
    i_tx_start_flag = 1'b1;
    step();
    i_tx_start_flag = 1'b0;
    exp_busy = 1'b1;
    exp_timeout = 1'b0;
    exp_frame_err = 1'b0;
    $display("exchange start tx_data=%h mode=%0d", data, mode);
    if (mode != 2) begin
      ok = 1'b0;
      for (int i = 0; i < 64; i++) begin
        if (last_hs_cnt != base) begin
          ok = 1'b1;
          break;
        end
        if (mode == 1) m_axis_tready = ~m_axis_tready;
        step();
      end
      if (!ok) chk("tx_wait_last_beat", DFB'(last_hs_cnt - base), DFB'(1));
      m_axis_tready = 1'b1;
    end
  endtask

  task automatic send_rx(input logic [W-1:0] data, input logic last);
    s_axis_tdata  = data;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    step();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // Beat 0 lands in the low bits; the end flag appears the cycle after the tlast beat.
  task automatic rx_frame(input logic [W-1:0] a, input logic [W-1:0] b);
    send_rx(a, 1'b0);
    send_rx(b, 1'b1);
    exp_rx_data = {b, a};
    exp_end = 1'b1;
    step();
    exp_end = 1'b0;
    exp_busy = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hs0, ec0;

    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_busy", DFB'(o_busy), DFB'(0));
    chk("rst_tvalid", DFB'(m_axis_tvalid), DFB'(0));
    chk("rst_tlast", DFB'(m_axis_tlast), DFB'(0));
    chk("rst_tdata", DFB'(m_axis_tdata), DFB'(0));
    chk("rst_rx_data", o_rx_data, DFB'(0));
    chk("rst_end_flag", DFB'(o_rx_end_flag), DFB'(0));
    chk("rst_timeout", DFB'(o_timeout), DFB'(0));
    chk("rst_frame_err", DFB'(o_frame_err), DFB'(0));
    step();
    i_rst = 1'b1;
    chk_on = 1'b1;
    step();
    step();

    // RX beat in IDLE is dropped silently; start while link is down is ignored.
    send_rx(64'hDEAD_BEEF_0000_0001, 1'b1);
    step();
    i_channel_up = 1'b0;
    i_tx_start_flag = 1'b1;
    step();
    i_tx_start_flag = 1'b0;
    i_channel_up = 1'b1;
    step();
    step();
    chk("link_down_start_ignored", DFB'(o_busy), DFB'(0));

    // Basic echo exchange.
    hs0 = hs_cnt;
    ec0 = end_cnt;
    start_exchange({64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 0);
    rx_frame(64'hA, 64'hB);
    chk("s1_beat0_literal", DFB'(hs_log[hs0 % 16]), DFB'(64'h1111_1111_1111_1111));
    chk("s1_beat1_literal", DFB'(hs_log[(hs0 + 1) % 16]), DFB'(64'h2222_2222_2222_2222));
    chk("s1_rx_data_literal", o_rx_data, {64'h0000_0000_0000_000B, 64'h0000_0000_0000_000A});
    chk("s1_handshakes", DFB'(hs_cnt - hs0), DFB'(2));
    chk("s1_end_pulses", DFB'(end_cnt - ec0), DFB'(1));

    // Backpressure: tready toggles during TX.
    hs0 = hs_cnt;
    start_exchange({64'h0BAD_F00D_4444_4444, 64'h3333_3333_CAFE_0001}, 1);
    rx_frame(64'hC0C0_0000_0000_0001, 64'hD0D0_0000_0000_0002);
    chk("s2_handshakes", DFB'(hs_cnt - hs0), DFB'(2));

    // Timeout: no RX beats.
    ec0 = end_cnt;
    start_exchange({64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666}, 0);
    repeat (15) step();
    chk("s3_timeout_not_yet", DFB'(o_timeout), DFB'(0));
    chk("s3_busy_before_expiry", DFB'(o_busy), DFB'(1));
    step();
    exp_timeout = 1'b1;
    exp_busy = 1'b0;
    chk("s3_timeout_set", DFB'(o_timeout), DFB'(1));
    step();
    chk("s3_no_end_flag", DFB'(end_cnt - ec0), DFB'(0));

    // Frame error: tlast on beat 0; the start also clears the sticky timeout.
    start_exchange({64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888}, 0);
    chk("s4_timeout_cleared", DFB'(o_timeout), DFB'(0));
    send_rx(64'h0000_0000_0000_0005, 1'b1);
    exp_frame_err = 1'b1;
    exp_busy = 1'b0;
    chk("s4_frame_err_set", DFB'(o_frame_err), DFB'(1));
    chk("s4_rx_data_kept", o_rx_data, {64'hD0D0_0000_0000_0002, 64'hC0C0_0000_0000_0001});
    step();

    // Start during RX is ignored and not queued.
    start_exchange({64'h9999_9999_9999_9999, 64'hAAAA_AAAA_AAAA_AAAA}, 0);
    i_tx_start_flag = 1'b1;
    step();
    i_tx_start_flag = 1'b0;
    rx_frame(64'hE, 64'hF);
    repeat (3) step();
    chk("s5_start_not_queued", DFB'(o_busy), DFB'(0));

    // Link drop mid-TX with the sink stalled.
    m_axis_tready = 1'b0;
    start_exchange({64'hBBBB_BBBB_BBBB_BBBB, 64'hCCCC_CCCC_CCCC_CCCC}, 2);
    step();
    i_channel_up = 1'b0;
    step();
    exp_busy = 1'b0;
    @(negedge i_clk);
    chk("s5_link_drop_busy", DFB'(o_busy), DFB'(0));
    chk("s5_link_drop_tvalid", DFB'(m_axis_tvalid), DFB'(0));
    i_channel_up = 1'b1;
    m_axis_tready = 1'b1;
    step();
    chk("s5_link_drop_no_flags", DFB'({o_timeout, o_frame_err}), DFB'(0));

    // Asynchronous reset mid-RX after one beat, then a full exchange.
    start_exchange({64'hDDDD_DDDD_DDDD_DDDD, 64'hEEEE_EEEE_EEEE_EEEE}, 0);
    send_rx(64'h0000_0000_0000_0011, 1'b0);
    #2;
    i_rst = 1'b0;
    exp_rx_data = '0;
    exp_busy = 1'b0;
    exp_end = 1'b0;
    exp_timeout = 1'b0;
    exp_frame_err = 1'b0;
    #1;
    chk("s6_rst_busy", DFB'(o_busy), DFB'(0));
    chk("s6_rst_rx_data", o_rx_data, DFB'(0));
    chk("s6_rst_tvalid", DFB'(m_axis_tvalid), DFB'(0));
    step();
    step();
    i_rst = 1'b1;
    step();
    hs0 = hs_cnt;
    ec0 = end_cnt;
    start_exchange({64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0}, 0);
    rx_frame(64'h0000_0000_0000_0021, 64'h0000_0000_0000_0022);
    chk("s6_post_rst_rx_data", o_rx_data, {64'h0000_0000_0000_0022, 64'h0000_0000_0000_0021});
    chk("s6_post_rst_end", DFB'(end_cnt - ec0), DFB'(1));
    chk("s6_post_rst_handshakes", DFB'(hs_cnt - hs0), DFB'(2));
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
